// File: rtl/nco_lut_ctrl_pkg.sv
// Shared constants, state encoding and bank-select helper for the NCO sine LUT controller.
package nco_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int MASK_W = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [MASK_W-1:0] WMASK_ALL = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

    // Address MSB picks the SRAM bank: 0 -> bank0 (csb00), 1 -> bank1 (csb10).
    function automatic logic bank_sel(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1];
    endfunction
endpackage

// File: rtl/nco_lut_ctrl_if.sv
// Loader stream, NCO read port and shared SRAM port of the LUT controller.
interface nco_lut_ctrl_if;
    import nco_pkg::*;

    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic              csb00;
    logic              csb10;
    logic              web0;
    logic [MASK_W-1:0] wmask0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] din0;
    logic [DATA_W-1:0] dout00;
    logic [DATA_W-1:0] dout10;

    modport master (
        input  ld_start, ld_valid, ld_data, rd_req, rd_addr, dout00, dout10,
        output ld_ready, ld_done, rd_gnt, rd_valid, rd_data,
        output csb00, csb10, web0, wmask0, addr0, din0
    );

    modport slave (
        output ld_start, ld_valid, ld_data, rd_req, rd_addr, dout00, dout10,
        input  ld_ready, ld_done, rd_gnt, rd_valid, rd_data,
        input  csb00, csb10, web0, wmask0, addr0, din0
    );
endinterface

// File: rtl/nco_lut_rd_pipe.sv
// Read return path: delays valid and bank tag by RD_LAT edges after the command register, then muxes the bank output.
module nco_lut_rd_pipe
    import nco_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    input  logic              bank,
    input  logic [DATA_W-1:0] dout00,
    input  logic [DATA_W-1:0] dout10,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data
);
    logic [RD_LAT-1:0] vld_sr;
    logic [RD_LAT-1:0] tag_sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_sr   <= '0;
            tag_sr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            vld_sr[0] <= issue;
            tag_sr[0] <= bank;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                tag_sr[i] <= tag_sr[i-1];
            end
            rd_valid <= vld_sr[RD_LAT-1];
            if (vld_sr[RD_LAT-1]) begin
                rd_data <= tag_sr[RD_LAT-1] ? dout10 : dout00;
            end
        end
    end
endmodule

// File: rtl/nco_lut_ctrl.sv
// NCO sine LUT controller: loads 256 words from a valid/ready stream, then serves phase reads
// through the single shared two-bank SRAM port.
//   state | meaning
//   IDLE  | after reset, table not trusted, waiting for ld_start
//   LOAD  | accepting table words, one SRAM write per accepted word
//   READY | table valid, granting NCO reads one per cycle
module nco_lut_ctrl
    import nco_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input logic            clk,
    input logic            reset,
    nco_lut_ctrl_if.master bus
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_LOAD  = LOAD;
    localparam logic [1:0] S_READY = READY;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              ld_ready_q;
    logic              ld_done_q;
    logic              accept;
    logic              gnt;
    logic              last_word;
    logic              rd_bank;

    logic              csb00_q;
    logic              csb10_q;
    logic              web0_q;
    logic [MASK_W-1:0] wmask0_q;
    logic [ADDR_W-1:0] addr0_q;
    logic [DATA_W-1:0] din0_q;
    logic              rd_valid_w;
    logic [DATA_W-1:0] rd_data_w;

    assign accept    = bus.ld_valid & ld_ready_q;
    assign gnt       = bus.rd_req & (state == S_READY);
    assign last_word = (cnt == ADDR_W'(DEPTH - 1));
    assign rd_bank   = bank_sel(bus.rd_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (last_word) begin
                            state      <= S_READY;
                            ld_ready_q <= 1'b0;
                            ld_done_q  <= 1'b1;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_IDLE, S_READY: begin
                    if (bus.ld_start) begin
                        state      <= S_LOAD;
                        ld_ready_q <= 1'b1;
                        ld_done_q  <= 1'b0;
                        cnt        <= '0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    ld_ready_q <= 1'b0;
                    ld_done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Writes and grants are mutually exclusive by state, so one command register serves both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csb00_q  <= 1'b1;
            csb10_q  <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
        end else if (accept) begin
            csb00_q  <= bank_sel(cnt);
            csb10_q  <= ~bank_sel(cnt);
            web0_q   <= 1'b0;
            wmask0_q <= WMASK_ALL;
            addr0_q  <= cnt;
            din0_q   <= bus.ld_data;
        end else if (gnt) begin
            csb00_q  <= rd_bank;
            csb10_q  <= ~rd_bank;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= bus.rd_addr;
        end else begin
            csb00_q  <= 1'b1;
            csb10_q  <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= '0;
        end
    end

    nco_lut_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
        .clk      (clk),
        .reset    (reset),
        .issue    (gnt),
        .bank     (rd_bank),
        .dout00   (bus.dout00),
        .dout10   (bus.dout10),
        .rd_valid (rd_valid_w),
        .rd_data  (rd_data_w)
    );

    assign bus.ld_ready = ld_ready_q;
    assign bus.ld_done  = ld_done_q;
    assign bus.rd_gnt   = gnt;
    assign bus.rd_valid = rd_valid_w;
    assign bus.rd_data  = rd_data_w;
    assign bus.csb00    = csb00_q;
    assign bus.csb10    = csb10_q;
    assign bus.web0     = web0_q;
    assign bus.wmask0   = wmask0_q;
    assign bus.addr0    = addr0_q;
    assign bus.din0     = din0_q;
endmodule

// File: tb/tb_nco_lut_ctrl.sv
// Bench for nco_lut_ctrl: two-bank SRAM model, port monitor and table/read scoreboard.
module tb_nco_lut_ctrl;
    import nco_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    nco_lut_ctrl_if bus();
    nco_lut_ctrl #(.RD_LAT(1)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        c0;
        logic        c1;
    } cmd_t;
    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rv_t;

    logic [31:0] bank0 [128];
    logic [31:0] bank1 [128];
    logic [31:0] tbl   [256];
    logic [31:0] model [256];
    cmd_t wr_q[$];
    cmd_t rc_q[$];
    rv_t  rv_q[$];
    int   conflicts = 0;
    int   bad_idle  = 0;

    // SRAM read data is presented while the read command is on the port.
    always_comb begin
        bus.dout00 = (!bus.csb00 && bus.web0) ? bank0[bus.addr0[6:0]] : 32'hDEAD_BEEF;
        bus.dout10 = (!bus.csb10 && bus.web0) ? bank1[bus.addr0[6:0]] : 32'hBAAD_F00D;
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (!bus.csb00 && !bus.csb10) conflicts++;
            if (!bus.web0) begin
                wr_q.push_back('{cyc, bus.addr0, bus.din0, bus.wmask0, bus.csb00, bus.csb10});
                for (int b = 0; b < 4; b++) begin
                    if (bus.wmask0[b] && !bus.csb00) bank0[bus.addr0[6:0]][8*b +: 8] = bus.din0[8*b +: 8];
                    if (bus.wmask0[b] && !bus.csb10) bank1[bus.addr0[6:0]][8*b +: 8] = bus.din0[8*b +: 8];
                end
            end else if (!bus.csb00 || !bus.csb10) begin
                rc_q.push_back('{cyc, bus.addr0, 32'h0, bus.wmask0, bus.csb00, bus.csb10});
            end else if (bus.wmask0 != 4'h0) begin
                bad_idle++;
            end
            if (bus.rd_valid) rv_q.push_back('{cyc, bus.rd_data});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random;
        for (int i = 0; i < 256; i++) tbl[i] = $urandom;
    endtask

    task automatic fill_sine;
        real v;
        for (int i = 0; i < 256; i++) begin
            v = $sin(2.0 * 3.14159265358979323846 * i / 256.0) * 2147483647.0;
            tbl[i] = 32'($rtoi(v + ((v >= 0.0) ? 0.5 : -0.5)));
        end
    endtask

    // Drives a table load; mode 0 = ld_valid always high, 1 = pattern 1,0,0,1, 2 = random.
    task automatic do_load(input int n_words, input int mode, input bit rd_noise, input bit send_start,
                           output int last_cyc, output int gnt_seen, output bit timeout);
        int idx = 0;
        int step = 0;
        logic v;
        gnt_seen = 0;
        timeout  = 1'b0;
        last_cyc = -1;
        if (send_start) begin
            bus.ld_start = 1'b1;
            tick();
            bus.ld_start = 1'b0;
        end
        while (idx < n_words) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((step % 4) == 0) || ((step % 4) == 3);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.ld_valid = v;
            bus.ld_data  = v ? tbl[idx] : $urandom;
            if (rd_noise) begin
                bus.rd_req  = 1'($urandom_range(0, 1));
                bus.rd_addr = 8'($urandom);
            end
            @(negedge clk);
            if (bus.rd_gnt) gnt_seen++;
            if (bus.ld_valid && bus.ld_ready) begin
                idx++;
                last_cyc = cyc;
            end
            tick();
            step++;
            if (step > 4000) begin
                timeout = 1'b1;
                break;
            end
        end
        bus.ld_valid = 1'b0;
        bus.rd_req   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.ld_start = 1'b1; bus.ld_valid = 1'b0; bus.ld_data = '0;
        bus.rd_req = 1'b1;   bus.rd_addr = 8'd200;
        repeat (3) tick();
        @(negedge clk);
        checks++; if ({bus.csb00, bus.csb10, bus.web0} !== 3'b111) begin errors++; $display("FAIL reset_csb_web: got %b want 111", {bus.csb00, bus.csb10, bus.web0}); end
        checks++; if ({bus.wmask0, bus.addr0, bus.din0} !== 44'h0) begin errors++; $display("FAIL reset_cmd: got mask %h addr %h din %h want all 0", bus.wmask0, bus.addr0, bus.din0); end
        checks++; if ({bus.ld_ready, bus.ld_done, bus.rd_gnt, bus.rd_valid} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.ld_ready, bus.ld_done, bus.rd_gnt, bus.rd_valid}); end
        checks++; if (bus.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
        tick();
        reset = 1'b0; bus.ld_start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++; if ({bus.ld_ready, bus.rd_gnt, bus.csb00, bus.csb10, bus.web0} !== 5'b00111) begin errors++; $display("FAIL idle_after_reset: got %b want 00111", {bus.ld_ready, bus.rd_gnt, bus.csb00, bus.csb10, bus.web0}); end
        tick();
        bus.rd_req = 1'b0;
    endtask

    task automatic test_full_load;
        int last, gs, bad_addr, bad_data, bad_bank, bad_seq;
        bit to;
        fill_random();
        wr_q.delete(); rc_q.delete(); conflicts = 0;
        do_load(256, 0, 1'b0, 1'b1, last, gs, to);
        checks++; if (to) begin errors++; $display("FAIL full_load_timeout: got timeout want 256 accepts"); end
        @(negedge clk);
        checks++; if ({bus.ld_done, bus.ld_ready} !== 2'b10 || cyc != last + 1) begin errors++; $display("FAIL full_load_done: got done/ready %b at cyc %0d want 10 at %0d", {bus.ld_done, bus.ld_ready}, cyc, last + 1); end
        tick();
        checks++; if (wr_q.size() != 256) begin errors++; $display("FAIL full_load_nwr: got %0d want 256", wr_q.size()); end
        bad_addr = 0; bad_data = 0; bad_bank = 0; bad_seq = 0;
        for (int i = 0; i < wr_q.size() && i < 256; i++) begin
            if (wr_q[i].addr != 8'(i)) bad_addr++;
            if (wr_q[i].data !== tbl[i] || wr_q[i].mask !== 4'hF) bad_data++;
            if ({wr_q[i].c0, wr_q[i].c1} !== ((i < 128) ? 2'b01 : 2'b10)) bad_bank++;
            if (wr_q[i].cyc != wr_q[0].cyc + i) bad_seq++;
        end
        checks++; if (bad_addr != 0) begin errors++; $display("FAIL full_load_addr: got %0d wrong addresses want 0", bad_addr); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL full_load_data: got %0d wrong words want 0", bad_data); end
        checks++; if (bad_bank != 0) begin errors++; $display("FAIL full_load_bank: got %0d wrong chip selects want 0", bad_bank); end
        checks++; if (bad_seq != 0) begin errors++; $display("FAIL full_load_consecutive: got %0d gaps want 0", bad_seq); end
        checks++; if (conflicts != 0 || rc_q.size() != 0) begin errors++; $display("FAIL full_load_port: got %0d conflicts %0d reads want 0 0", conflicts, rc_q.size()); end
        for (int i = 0; i < 256; i++) model[i] = tbl[i];
    endtask

    task automatic test_bubbles;
        int last, gs, bad, span;
        bit to;
        fill_random();
        wr_q.delete(); rc_q.delete(); bad_idle = 0; conflicts = 0;
        do_load(256, 1, 1'b0, 1'b1, last, gs, to);
        checks++; if (to) begin errors++; $display("FAIL bubble_timeout: got timeout want 256 accepts"); end
        tick();
        checks++; if (wr_q.size() != 256) begin errors++; $display("FAIL bubble_nwr: got %0d want 256", wr_q.size()); end
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < 256; i++)
            if (wr_q[i].addr != 8'(i) || wr_q[i].data !== tbl[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bubble_contig: got %0d bad writes want 0", bad); end
        span = (wr_q.size() > 0) ? wr_q[wr_q.size()-1].cyc - wr_q[0].cyc + 1 : 0;
        checks++; if (span <= 256 || bad_idle != 0 || rc_q.size() != 0 || conflicts != 0) begin errors++; $display("FAIL bubble_idle: got span %0d bad_idle %0d reads %0d conflicts %0d want span>256 and 0 0 0", span, bad_idle, rc_q.size(), conflicts); end
        for (int i = 0; i < 256; i++) model[i] = tbl[i];
    endtask

    task automatic test_rand_reads;
        rv_t  exp_rv[$];
        cmd_t exp_rc[$];
        int bad_gnt, bad_rv, bad_rc;
        logic [7:0] a;
        rv_q.delete(); rc_q.delete();
        bad_gnt = 0;
        for (int k = 0; k < 40; k++) begin
            a = 8'($urandom);
            bus.rd_req  = ($urandom_range(0, 3) != 0);
            bus.rd_addr = a;
            @(negedge clk);
            if (bus.rd_gnt !== bus.rd_req) bad_gnt++;
            if (bus.rd_req) begin
                exp_rv.push_back('{cyc + 2, model[a]});
                exp_rc.push_back('{cyc + 1, a, 32'h0, 4'h0, a[7], ~a[7]});
            end
            tick();
        end
        bus.rd_req = 1'b0;
        repeat (4) tick();
        checks++; if (bad_gnt != 0) begin errors++; $display("FAIL rand_gnt: got %0d wrong grants want 0", bad_gnt); end
        checks++; if (rv_q.size() != exp_rv.size()) begin errors++; $display("FAIL rand_nvalid: got %0d want %0d", rv_q.size(), exp_rv.size()); end
        bad_rv = 0; bad_rc = 0;
        for (int i = 0; i < exp_rv.size() && i < rv_q.size(); i++)
            if (rv_q[i].cyc != exp_rv[i].cyc || rv_q[i].data !== exp_rv[i].data) bad_rv++;
        for (int i = 0; i < exp_rc.size() && i < rc_q.size(); i++)
            if (rc_q[i].cyc != exp_rc[i].cyc || rc_q[i].addr != exp_rc[i].addr || rc_q[i].mask !== 4'h0 ||
                {rc_q[i].c0, rc_q[i].c1} !== {exp_rc[i].c0, exp_rc[i].c1}) bad_rc++;
        checks++; if (bad_rv != 0) begin errors++; $display("FAIL rand_rd_data: got %0d wrong returns want 0", bad_rv); end
        checks++; if (bad_rc != 0 || rc_q.size() != exp_rc.size()) begin errors++; $display("FAIL rand_rd_cmd: got %0d bad of %0d cmds want 0 of %0d", bad_rc, rc_q.size(), exp_rc.size()); end
    endtask

    task automatic test_sine_reads;
        int last, gs, cg;
        logic [2:0] g;
        bit to;
        fill_sine();
        do_load(256, 2, 1'b0, 1'b1, last, gs, to);
        checks++; if (to) begin errors++; $display("FAIL sine_load_timeout: got timeout want 256 accepts"); end
        for (int i = 0; i < 256; i++) model[i] = tbl[i];
        tick();
        rv_q.delete();
        bus.rd_req = 1'b1; bus.rd_addr = 8'd64;
        @(negedge clk); g[0] = bus.rd_gnt; cg = cyc;
        tick(); bus.rd_addr = 8'd192;
        @(negedge clk); g[1] = bus.rd_gnt;
        tick(); bus.rd_addr = 8'd0;
        @(negedge clk); g[2] = bus.rd_gnt;
        tick(); bus.rd_req = 1'b0;
        repeat (4) tick();
        checks++; if (g !== 3'b111) begin errors++; $display("FAIL sine_gnt: got %b want 111", g); end
        checks++; if (rv_q.size() != 3) begin errors++; $display("FAIL sine_nvalid: got %0d want 3", rv_q.size()); end
        if (rv_q.size() >= 3) begin
            checks++; if (rv_q[0].cyc != cg + 2 || rv_q[1].cyc != cg + 3 || rv_q[2].cyc != cg + 4) begin errors++; $display("FAIL sine_timing: got %0d %0d %0d want %0d %0d %0d", rv_q[0].cyc, rv_q[1].cyc, rv_q[2].cyc, cg + 2, cg + 3, cg + 4); end
            checks++; if (rv_q[0].data !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sine_64: got %h want 7fffffff", rv_q[0].data); end
            checks++; if (rv_q[1].data !== 32'h8000_0001) begin errors++; $display("FAIL sine_192: got %h want 80000001", rv_q[1].data); end
            checks++; if (rv_q[2].data !== 32'h0000_0000) begin errors++; $display("FAIL sine_0: got %h want 00000000", rv_q[2].data); end
        end
    endtask

    task automatic test_load_restart;
        int last, gs, gc, bad;
        logic [7:0] a;
        logic g;
        bit to;
        rv_q.delete(); rc_q.delete(); wr_q.delete();
        a = 8'($urandom);
        bus.rd_req = 1'b1; bus.rd_addr = a;
        @(negedge clk); g = bus.rd_gnt; gc = cyc;
        tick(); bus.rd_req = 1'b0; bus.ld_start = 1'b1;
        tick(); bus.ld_start = 1'b0;
        @(negedge clk);
        checks++; if (g !== 1'b1) begin errors++; $display("FAIL restart_gnt: got %b want 1", g); end
        checks++; if ({bus.ld_done, bus.ld_ready, bus.rd_valid} !== 3'b011) begin errors++; $display("FAIL restart_flags: got done/ready/valid %b want 011", {bus.ld_done, bus.ld_ready, bus.rd_valid}); end
        checks++; if (bus.rd_data !== model[a]) begin errors++; $display("FAIL restart_rd_data: got %h want %h", bus.rd_data, model[a]); end
        tick();
        fill_random();
        do_load(256, 2, 1'b1, 1'b0, last, gs, to);
        tick();
        checks++; if (to) begin errors++; $display("FAIL restart_timeout: got timeout want 256 accepts"); end
        checks++; if (gs != 0) begin errors++; $display("FAIL load_gnt: got %0d grants during load want 0", gs); end
        checks++; if (rc_q.size() != 1 || (rc_q.size() > 0 && rc_q[0].cyc != gc + 1)) begin errors++; $display("FAIL load_rd_cmd: got %0d read cmds want 1 at cyc %0d", rc_q.size(), gc + 1); end
        checks++; if (wr_q.size() != 256 || wr_q[0].addr != 8'd0 || wr_q[0].cyc <= gc + 1) begin errors++; $display("FAIL restart_first_wr: got n %0d addr %0d cyc %0d want 256 0 >%0d", wr_q.size(), wr_q.size() > 0 ? wr_q[0].addr : 8'hFF, wr_q.size() > 0 ? wr_q[0].cyc : -1, gc + 1); end
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < 256; i++)
            if (wr_q[i].addr != 8'(i) || wr_q[i].data !== tbl[i]) bad++;
        checks++; if (bad != 0 || bus.ld_done !== 1'b1) begin errors++; $display("FAIL restart_table: got %0d bad writes done %b want 0 1", bad, bus.ld_done); end
        for (int i = 0; i < 256; i++) model[i] = tbl[i];
    endtask

    task automatic test_reset_mid_load;
        int last, gs, bad;
        bit to;
        logic pre_web;
        fill_random();
        wr_q.delete();
        do_load(100, 0, 1'b0, 1'b1, last, gs, to);
        pre_web = bus.web0;
        reset = 1'b1;
        #1;
        checks++; if (to || pre_web !== 1'b0) begin errors++; $display("FAIL mid_load_active: got web0 %b timeout %b want 0 0", pre_web, to); end
        checks++; if ({bus.csb00, bus.csb10, bus.web0, bus.ld_done, bus.ld_ready} !== 5'b11100) begin errors++; $display("FAIL mid_load_async_reset: got %b want 11100", {bus.csb00, bus.csb10, bus.web0, bus.ld_done, bus.ld_ready}); end
        tick();
        reset = 1'b0;
        tick();
        wr_q.delete();
        fill_random();
        do_load(256, 2, 1'b0, 1'b1, last, gs, to);
        tick();
        bad = 0;
        for (int i = 0; i < wr_q.size() && i < 256; i++)
            if (wr_q[i].addr != 8'(i) || wr_q[i].data !== tbl[i]) bad++;
        checks++; if (to || wr_q.size() != 256 || bad != 0) begin errors++; $display("FAIL reload_after_reset: got n %0d bad %0d timeout %b want 256 0 0", wr_q.size(), bad, to); end
        checks++; if (bus.ld_done !== 1'b1) begin errors++; $display("FAIL reload_done: got %b want 1", bus.ld_done); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_load();
        test_bubbles();
        test_rand_reads();
        test_sine_reads();
        test_load_restart();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
